dff_bank_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a small bank of D-flip-flop storage registers shared by NREQ requesters.
- Each requester issues a single read or write; the block serialises access, commits writes and returns read data under a req/gnt handshake.
- It sits between the user-input decode logic and the storage flops, so all bank updates happen through one controlled write port.

---
 rtl/dff_bank_arbiter.sv | 144 ++++++++++++++
 tb/tb_dff_bank_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that serialises single read/write ops from NREQ requesters
// onto a small DFF register bank via one write port; two-state IDLE/ACK sequencer.
module dff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         we,
    input  logic [NREQ*AW-1:0]      addr,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    input  logic                    clr,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        rdata,
    output logic                    busy,
    output logic [DEPTH*WIDTH-1:0]  bank_q
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    logic              found;
    logic [PW-1:0]     cand;
    logic [PW-1:0]     sel;
    logic              sel_we;
    logic [AW-1:0]     sel_addr;
    logic [WIDTH-1:0]  sel_wdata;

    // Rotating scan from ptr_q; the wrap is explicit so NREQ need not be a power of two.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = ptr_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
            cand = (cand == PW'(NREQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel == PW'(i)) begin
                sel_we    = we[i];
                sel_addr  = addr[i*AW +: AW];
                sel_wdata = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            mem_d[j] = mem_q[j];
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = sel;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    ptr_d   = (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
                    state_d = ACK;
                    if (sel_we) begin
                        mem_d[sel_addr] = sel_wdata;
                    end
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // clr wins over a write committing on the same edge
        if (clr) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                mem_d[j] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                mem_q[j] <= mem_d[j];
            end
        end
    end

    // Outputs decode only registered state, so nothing reaches them combinationally from req/clr.
    always_comb begin
        gnt   = '0;
        rdata = '0;
        busy  = (state_q == ACK);
        if (state_q == ACK) begin
            gnt[win_q] = 1'b1;
            if (!we_q) begin
                rdata = mem_q[addr_q];
            end
        end
    end

    always_comb begin
        bank_q = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            bank_q[j*WIDTH +: WIDTH] = mem_q[j];
        end
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter: directed vector table, hand-written
// clr/reset corner sequences, then randomized requesters against a reference model.
module tb_dff_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic                   clk = 1'b0;
    logic                   rst, clr;
    logic [NREQ-1:0]        req, we;
    logic [NREQ*AW-1:0]     addr;
    logic [NREQ*WIDTH-1:0]  wdata;
    logic [NREQ-1:0]        gnt;
    logic [WIDTH-1:0]       rdata;
    logic                   busy;
    logic [DEPTH*WIDTH-1:0] bank_q;

    always #5 clk = ~clk;

    dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .clr    (clr),
        .gnt    (gnt),
        .rdata  (rdata),
        .busy   (busy),
        .bank_q (bank_q)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: transaction-level view (pending ack, round-robin pointer, bank array).
    int unsigned m_bank [DEPTH];
    int          m_ptr, m_win, m_addr;
    bit          m_ack, m_we;

    task automatic model_step();
        int w;
        if (rst) begin
            foreach (m_bank[j]) m_bank[j] = 0;
            m_ptr = 0; m_ack = 0; m_win = 0; m_we = 0; m_addr = 0;
        end else begin
            if (m_ack) begin
                m_ack = 0;
            end else if (req != '0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                m_ack  = 1;
                m_win  = w;
                m_we   = we[w];
                m_addr = int'(addr[w*AW +: AW]);
                if (m_we) m_bank[m_addr] = int'(wdata[w*WIDTH +: WIDTH]);
                m_ptr  = (w + 1) % NREQ;
            end
            if (clr) foreach (m_bank[j]) m_bank[j] = 0;
        end
    endtask

    function automatic logic [NREQ-1:0] model_gnt();
        logic [NREQ-1:0] g;
        g = '0;
        if (m_ack) g[m_win] = 1'b1;
        return g;
    endfunction

    function automatic logic [WIDTH-1:0] model_rdata();
        return (m_ack && !m_we) ? WIDTH'(m_bank[m_addr]) : '0;
    endfunction

    function automatic logic [DEPTH*WIDTH-1:0] model_bank();
        logic [DEPTH*WIDTH-1:0] b;
        b = '0;
        for (int j = 0; j < DEPTH; j++) b[j*WIDTH +: WIDTH] = WIDTH'(m_bank[j]);
        return b;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    typedef struct {
        bit          rst;
        bit          clr;
        logic [3:0]  req;
        logic [3:0]  we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        bit          busy;
        logic [7:0]  rdata;
        logic [31:0] bank;
    } vec_t;

    function automatic vec_t mk(bit r, bit c, logic [3:0] rq, logic [3:0] w, logic [7:0] a,
                                logic [31:0] wd, logic [3:0] g, bit b, logic [7:0] rd,
                                logic [31:0] bk);
        vec_t v;
        v.rst = r; v.clr = c; v.req = rq; v.we = w; v.addr = a; v.wdata = wd;
        v.gnt = g; v.busy = b; v.rdata = rd; v.bank = bk;
        return v;
    endfunction

    vec_t            tbl[$];
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] g;

    initial begin
        rst = 1'b1; clr = 1'b0; req = 4'hF; we = '0; addr = 8'hE4; wdata = '0;

        // reset held with all requests up
        tbl.push_back(mk(1,0,4'hF,4'h0,8'hE4,32'h0,        4'h0,0,8'h00,32'h00000000));
        tbl.push_back(mk(1,0,4'hF,4'h0,8'hE4,32'h0,        4'h0,0,8'h00,32'h00000000));
        tbl.push_back(mk(0,0,4'hF,4'h0,8'hE4,32'h0,        4'h1,1,8'h00,32'h00000000));
        tbl.push_back(mk(0,0,4'h0,4'h0,8'hE4,32'h0,        4'h0,0,8'h00,32'h00000000));
        // single write then read of addr 2
        tbl.push_back(mk(0,0,4'h1,4'h1,8'h02,32'h000000A5, 4'h1,1,8'h00,32'h00A50000));
        tbl.push_back(mk(0,0,4'h0,4'h0,8'h02,32'h000000A5, 4'h0,0,8'h00,32'h00A50000));
        tbl.push_back(mk(0,0,4'h1,4'h0,8'h02,32'h000000A5, 4'h1,1,8'hA5,32'h00A50000));
        tbl.push_back(mk(0,0,4'h0,4'h0,8'h02,32'h000000A5, 4'h0,0,8'h00,32'h00A50000));
        tbl.push_back(mk(1,0,4'h0,4'h0,8'h02,32'h000000A5, 4'h0,0,8'h00,32'h00000000));
        // round-robin with all four writing 0x10+i to addr i
        tbl.push_back(mk(0,0,4'hF,4'hF,8'hE4,32'h13121110, 4'h1,1,8'h00,32'h00000010));
        tbl.push_back(mk(0,0,4'hE,4'hF,8'hE4,32'h13121110, 4'h0,0,8'h00,32'h00000010));
        tbl.push_back(mk(0,0,4'hE,4'hF,8'hE4,32'h13121110, 4'h2,1,8'h00,32'h00001110));
        tbl.push_back(mk(0,0,4'hC,4'hF,8'hE4,32'h13121110, 4'h0,0,8'h00,32'h00001110));
        tbl.push_back(mk(0,0,4'hC,4'hF,8'hE4,32'h13121110, 4'h4,1,8'h00,32'h00121110));
        tbl.push_back(mk(0,0,4'h8,4'hF,8'hE4,32'h13121110, 4'h0,0,8'h00,32'h00121110));
        tbl.push_back(mk(0,0,4'h8,4'hF,8'hE4,32'h13121110, 4'h8,1,8'h00,32'h13121110));
        tbl.push_back(mk(0,0,4'h0,4'h0,8'hE4,32'h13121110, 4'h0,0,8'h00,32'h13121110));
        // fairness wrap: after req2, req3 beats req0
        tbl.push_back(mk(0,0,4'h4,4'h0,8'hE4,32'h0,        4'h4,1,8'h12,32'h13121110));
        tbl.push_back(mk(0,0,4'h9,4'h0,8'hE4,32'h0,        4'h0,0,8'h00,32'h13121110));
        tbl.push_back(mk(0,0,4'h9,4'h0,8'hE4,32'h0,        4'h8,1,8'h13,32'h13121110));
        tbl.push_back(mk(0,0,4'h1,4'h0,8'hE4,32'h0,        4'h0,0,8'h00,32'h13121110));
        tbl.push_back(mk(0,0,4'h1,4'h0,8'hE4,32'h0,        4'h1,1,8'h10,32'h13121110));
        tbl.push_back(mk(0,0,4'h0,4'h0,8'hE4,32'h0,        4'h0,0,8'h00,32'h13121110));
        // clr on the commit edge discards req1's write but still grants
        tbl.push_back(mk(0,1,4'h2,4'h2,8'hE0,32'h1312FF10, 4'h2,1,8'h00,32'h00000000));
        tbl.push_back(mk(0,0,4'h0,4'h0,8'hE0,32'h1312FF10, 4'h0,0,8'h00,32'h00000000));
        tbl.push_back(mk(0,0,4'h2,4'h2,8'hE0,32'h1312FF10, 4'h2,1,8'h00,32'h000000FF));
        tbl.push_back(mk(0,0,4'h0,4'h0,8'hE0,32'h1312FF10, 4'h0,0,8'h00,32'h000000FF));

        foreach (tbl[n]) begin
            rst = tbl[n].rst; clr = tbl[n].clr; req = tbl[n].req;
            we = tbl[n].we; addr = tbl[n].addr; wdata = tbl[n].wdata;
            cycle();
            check($sformatf("vec%0d_gnt", n),   64'(gnt),    64'(tbl[n].gnt));
            check($sformatf("vec%0d_busy", n),  64'(busy),   64'(tbl[n].busy));
            check($sformatf("vec%0d_rdata", n), 64'(rdata),  64'(tbl[n].rdata));
            check($sformatf("vec%0d_bank", n),  64'(bank_q), 64'(tbl[n].bank));
        end

        // read whose ACK cycle has clr high returns the pre-clear value
        req = 4'h2; we = 4'h0; addr = 8'hE0; clr = 1'b0;
        @(posedge clk);
        model_step();
        #1 clr = 1'b1;
        @(negedge clk);
        check("clrread_gnt",   64'(gnt),   64'h2);
        check("clrread_rdata", 64'(rdata), 64'hFF);
        req = 4'h0;
        cycle();
        check("clrread_bank",  64'(bank_q), 64'h0);
        check("clrread_gnt2",  64'(gnt),    64'h0);
        clr = 1'b0;

        // reset during ACK drops the transaction and returns ptr to 0
        req = 4'h4; we = 4'h4; addr = 8'hE4; wdata = 32'h00550000;
        cycle();
        check("midrst_gnt",  64'(gnt),    64'h4);
        check("midrst_bank", 64'(bank_q), 64'h00550000);
        rst = 1'b1; req = 4'h0;
        cycle();
        check("midrst_gnt_after",  64'(gnt),    64'h0);
        check("midrst_busy_after", 64'(busy),   64'h0);
        check("midrst_bank_after", 64'(bank_q), 64'h0);
        rst = 1'b0; req = 4'hF; we = 4'h0;
        cycle();
        check("midrst_ptr0_gnt", 64'(gnt), 64'h1);
        req = 4'h0;
        cycle();
        check("midrst_idle_gnt", 64'(gnt), 64'h0);

        // randomized requesters, each holding req until its grant is seen
        pend = '0;
        for (int n = 0; n < 3000; n++) begin
            g = model_gnt();
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] && g[i]) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    we[i] = 1'($urandom_range(0, 1));
                    addr[i*AW +: AW] = AW'($urandom);
                    wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
            req = pend;
            rst = ($urandom_range(0, 99) == 0);
            clr = ($urandom_range(0, 29) == 0);
            cycle();
            check("rand_gnt",   64'(gnt),    64'(model_gnt()));
            check("rand_busy",  64'(busy),   64'(m_ack));
            check("rand_rdata", 64'(rdata),  64'(model_rdata()));
            check("rand_bank",  64'(bank_q), 64'(model_bank()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
